// File: rtl/bcd_stopwatch_if.sv
// Control and display signals between the tick divider / buttons and the BCD stopwatch.
// Tick_in, Start and Lap act on rising edges; Clear is a level; all outputs are registered.
interface bcd_stopwatch_if #(
    parameter int DIGITS = 4
);
    logic                  Tick_in;
    logic                  Start;
    logic                  Lap;
    logic                  Clear;
    logic [4*DIGITS-1:0]   Count;
    logic [4*DIGITS-1:0]   Disp;
    logic                  Running;
    logic                  Ovf;
    logic [2:0]            state_dbg;

    modport master (
        output Tick_in, Start, Lap, Clear,
        input  Count, Disp, Running, Ovf, state_dbg
    );

    modport slave (
        input  Tick_in, Start, Lap, Clear,
        output Count, Disp, Running, Ovf, state_dbg
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch counting rising edges of a divided tick, with run/pause, lap-freeze and clear.
// Everything runs on Clk_in; the divided clock is only sampled as data.
module bcd_stopwatch #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic           Clk_in,
    input  logic           Rst,
    bcd_stopwatch_if.slave sw
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LAP   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_n;
    logic [4*DIGITS-1:0] count_q, count_n, count_inc;
    logic [4*DIGITS-1:0] disp_q, disp_n;
    logic                running_q, running_n;
    logic                ovf_q, ovf_n;
    logic                tick_q, start_q, lap_q;
    logic                tick_e, start_e, lap_e;
    logic                all_nines, carry, live, counting;

    assign tick_e  = sw.Tick_in & ~tick_q;
    assign start_e = sw.Start   & ~start_q;
    assign lap_e   = sw.Lap     & ~lap_q;

    // Ripple carry across all digits in one cycle; all-9s rolls every digit to 0.
    always_comb begin
        carry     = 1'b1;
        all_nines = 1'b1;
        count_inc = count_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (count_q[4*k +: 4] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) count_inc[4*k +: 4] = 4'd0;
                else                           count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
            end
            carry = carry & (count_q[4*k +: 4] == 4'd9);
        end
    end

    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        disp_n   = disp_q;
        ovf_n    = ovf_q;
        live     = (state_q == RUN) || (state_q == LAP);
        counting = live && tick_e;
        if (sw.Clear) begin
            state_n = IDLE;
            count_n = '0;
            disp_n  = '0;
            ovf_n   = 1'b0;
        end else begin
            if (counting) begin
                if (all_nines) ovf_n = 1'b1;
                if (!(all_nines && WRAP == 0)) count_n = count_inc;
            end
            case (state_q)
                IDLE:    if (start_e) state_n = RUN;
                RUN:     if (start_e) state_n = PAUSE; else if (lap_e) state_n = LAP;
                LAP:     if (start_e) state_n = PAUSE; else if (lap_e) state_n = RUN;
                PAUSE:   if (start_e) state_n = RUN;
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
            // Saturation outranks any button edge on the same cycle.
            if (counting && all_nines && WRAP == 0) state_n = DONE;
            // Disp snapshots the count on LAP entry (tick included) and holds while in LAP.
            if (state_n != LAP || state_q != LAP) disp_n = count_n;
        end
        running_n = (state_n == RUN) || (state_n == LAP);
    end

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
            tick_q    <= 1'b1;
            start_q   <= 1'b1;
            lap_q     <= 1'b1;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            disp_q    <= disp_n;
            running_q <= running_n;
            ovf_q     <= ovf_n;
            tick_q    <= sw.Tick_in;
            start_q   <= sw.Start;
            lap_q     <= sw.Lap;
        end
    end

    assign sw.Count     = count_q;
    assign sw.Disp      = disp_q;
    assign sw.Running   = running_q;
    assign sw.Ovf       = ovf_q;
    assign sw.state_dbg = state_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: a WRAP=1 and a WRAP=0 instance share one stimulus stream and are
// compared every cycle against an integer-valued model, plus literal checkpoints.
module tb_bcd_stopwatch;
    localparam int MAXV = 9999;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3, M_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_in = 1'b0, start = 1'b0, lap = 1'b0, clear = 1'b0;

    int checks = 0;
    int errors = 0;

    bcd_stopwatch_if #(.DIGITS(4)) sw1 ();
    bcd_stopwatch_if #(.DIGITS(4)) sw0 ();

    assign sw1.Tick_in = tick_in;
    assign sw1.Start   = start;
    assign sw1.Lap     = lap;
    assign sw1.Clear   = clear;
    assign sw0.Tick_in = tick_in;
    assign sw0.Start   = start;
    assign sw0.Lap     = lap;
    assign sw0.Clear   = clear;

    bcd_stopwatch #(.DIGITS(4), .WRAP(1)) dut_wrap (.Clk_in(clk), .Rst(rst), .sw(sw1));
    bcd_stopwatch #(.DIGITS(4), .WRAP(0)) dut_sat  (.Clk_in(clk), .Rst(rst), .sw(sw0));

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // model: index 1 = WRAP=1 instance, index 0 = WRAP=0 instance
    int   m_cnt[2], m_disp[2], m_st[2];
    bit   m_ovf[2];
    bit   p_tick, p_start, p_lap;
    bit   model_valid = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit te, se, le, live, sat;
        int c, nxt;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]  <= 0;
                m_disp[i] <= 0;
                m_st[i]   <= M_IDLE;
                m_ovf[i]  <= 1'b0;
            end
            p_tick      <= 1'b1;
            p_start     <= 1'b1;
            p_lap       <= 1'b1;
            model_valid <= 1'b1;
        end else begin
            te = tick_in && !p_tick;
            se = start && !p_start;
            le = lap && !p_lap;
            p_tick  <= tick_in;
            p_start <= start;
            p_lap   <= lap;
            for (int i = 0; i < 2; i++) begin
                if (clear) begin
                    m_cnt[i]  <= 0;
                    m_disp[i] <= 0;
                    m_st[i]   <= M_IDLE;
                    m_ovf[i]  <= 1'b0;
                end else begin
                    live = (m_st[i] == M_RUN) || (m_st[i] == M_LAP);
                    sat  = live && te && (m_cnt[i] == MAXV);
                    c    = m_cnt[i];
                    if (live && te) begin
                        if (c == MAXV) c = (i == 1) ? 0 : MAXV;
                        else           c = c + 1;
                    end
                    if (sat) m_ovf[i] <= 1'b1;
                    nxt = m_st[i];
                    if (se) begin
                        if (m_st[i] == M_IDLE || m_st[i] == M_PAUSE) nxt = M_RUN;
                        else if (live)                              nxt = M_PAUSE;
                    end else if (le) begin
                        if (m_st[i] == M_RUN)      nxt = M_LAP;
                        else if (m_st[i] == M_LAP) nxt = M_RUN;
                    end
                    if (sat && i == 0) nxt = M_DONE;
                    if (!(nxt == M_LAP && m_st[i] == M_LAP)) m_disp[i] <= c;
                    m_cnt[i] <= c;
                    m_st[i]  <= nxt;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit digits_ok(input logic [15:0] v);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // scoreboard: every cycle after the first reset edge
    always @(negedge clk) begin
        if (model_valid) begin
            check("count_wrap",   sw1.Count,   to_bcd(m_cnt[1]));
            check("disp_wrap",    sw1.Disp,    to_bcd(m_disp[1]));
            check("running_wrap", sw1.Running, (m_st[1] == M_RUN || m_st[1] == M_LAP));
            check("ovf_wrap",     sw1.Ovf,     m_ovf[1]);
            check("count_sat",    sw0.Count,   to_bcd(m_cnt[0]));
            check("disp_sat",     sw0.Disp,    to_bcd(m_disp[0]));
            check("running_sat",  sw0.Running, (m_st[0] == M_RUN || m_st[0] == M_LAP));
            check("ovf_sat",      sw0.Ovf,     m_ovf[0]);
            check("digits_wrap",  digits_ok(sw1.Count), 1);
            check("digits_sat",   digits_ok(sw0.Count), 1);
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_pulse(input int hi, input int lo);
        tick_in = 1'b1; cyc(hi);
        tick_in = 1'b0; cyc(lo);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_pulse(1, 1);
    endtask

    task automatic press_start();
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(1);
    endtask

    task automatic press_lap();
        lap = 1'b1; cyc(1);
        lap = 1'b0; cyc(1);
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(1);
        clear = 1'b0; cyc(1);
    endtask

    initial begin
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("reset_count",   sw1.Count,   16'h0000);
        check("reset_running", sw1.Running, 0);
        check("reset_ovf",     sw1.Ovf,     0);

        // divider-shaped ticks
        press_start();
        for (int i = 0; i < 25; i++) tick_pulse(5, 5);
        check("t1_count",   sw1.Count,   16'h0025);
        check("t1_disp",    sw1.Disp,    16'h0025);
        check("t1_running", sw1.Running, 1);
        check("t1_ovf",     sw1.Ovf,     0);

        // digit carries
        do_clear();
        press_start();
        ticks(9);
        check("t2_0009", sw1.Count, 16'h0009);
        ticks(1);
        check("t2_0010", sw1.Count, 16'h0010);
        ticks(989);
        check("t2_0999", sw1.Count, 16'h0999);
        ticks(1);
        check("t2_1000", sw1.Count, 16'h1000);

        // overflow: wrap vs saturate
        ticks(8999);
        check("t3_9999_wrap", sw1.Count, 16'h9999);
        check("t3_9999_sat",  sw0.Count, 16'h9999);
        ticks(1);
        check("t3_wrap_count",   sw1.Count,   16'h0000);
        check("t3_wrap_ovf",     sw1.Ovf,     1);
        check("t3_wrap_running", sw1.Running, 1);
        check("t3_sat_count",    sw0.Count,   16'h9999);
        check("t3_sat_ovf",      sw0.Ovf,     1);
        check("t3_sat_running",  sw0.Running, 0);
        ticks(3);
        press_start();
        ticks(2);
        check("t3_done_count",   sw0.Count,   16'h9999);
        check("t3_done_running", sw0.Running, 0);
        check("t3_wrap_paused",  sw1.Count,   16'h0003);
        do_clear();
        check("t3_clr_count", sw0.Count,   16'h0000);
        check("t3_clr_ovf",   sw0.Ovf,     0);
        check("t3_clr_run",   sw0.Running, 0);
        press_start();
        ticks(1);
        check("t3_restart", sw0.Count, 16'h0001);

        // lap freeze
        do_clear();
        press_start();
        ticks(12);
        check("t4_0012", sw1.Count, 16'h0012);
        press_lap();
        ticks(5);
        check("t4_lap_disp",  sw1.Disp,  16'h0012);
        check("t4_lap_count", sw1.Count, 16'h0017);
        press_lap();
        check("t4_unlap_disp", sw1.Disp,    16'h0017);
        check("t4_unlap_run",  sw1.Running, 1);
        press_start();
        check("t4_pause_run", sw1.Running, 0);
        ticks(3);
        check("t4_pause_count", sw1.Count, 16'h0017);

        // simultaneous events
        do_clear();
        press_start();
        ticks(3);
        check("t5_0003", sw1.Count, 16'h0003);
        tick_in = 1'b1; start = 1'b1; cyc(1);
        tick_in = 1'b0; start = 1'b0; cyc(1);
        check("t5_tick_start_count", sw1.Count,   16'h0004);
        check("t5_tick_start_run",   sw1.Running, 0);
        press_start();
        tick_in = 1'b1; clear = 1'b1; cyc(1);
        tick_in = 1'b0; clear = 1'b0; cyc(1);
        check("t5_tick_clear_count", sw1.Count,   16'h0000);
        check("t5_tick_clear_run",   sw1.Running, 0);

        // inputs held high across reset release
        tick_in = 1'b1; start = 1'b1; rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("t6_held_count", sw1.Count,   16'h0000);
        check("t6_held_run",   sw1.Running, 0);
        start = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        check("t6_restart_run", sw1.Running, 1);
        cyc(2);
        check("t6_tick_held", sw1.Count, 16'h0000);
        tick_in = 1'b0; cyc(1);
        tick_in = 1'b1; cyc(1);
        check("t6_tick_again", sw1.Count, 16'h0001);
        start = 1'b0; tick_in = 1'b0; cyc(1);
        start = 1'b1; lap = 1'b1; cyc(1);
        start = 1'b0; lap = 1'b0; cyc(1);
        check("t6_start_beats_lap", sw1.Running, 0);
        press_lap();
        check("t6_lap_in_pause", sw1.Running, 0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Downstream consumer of the divide-by-10 clock divider output.
- Treats the divided clock as a tick. Detects its rising edges in the Clk_in domain and counts ticks in a DIGITS-digit BCD counter.
- Start/stop, lap-freeze and clear control, for the seven-segment display stage.
- The divided clock is never used as a clock; all logic runs on Clk_in.

Parameters:
DIGITS, 4, number of BCD digits (digit 0 least significant)
WRAP, 1, 1 = roll over from all-9s to zero; 0 = saturate at all-9s and stop

Ports:
Clk_in  input  1  system clock, all logic on rising edge
Rst  input  1  synchronous active-high reset
Tick_in  input  1  divided clock from divider (Clk_out), synchronous to Clk_in
Start  input  1  start/stop button, rising edge toggles run/pause
Lap  input  1  lap button, rising edge toggles display freeze
Clear  input  1  level, synchronous clear to zero/IDLE
Count  output  4*DIGITS  live BCD count, digit k at [4k+3:4k]
Disp  output  4*DIGITS  BCD value for display (frozen in LAP)
Running  output  1  1 in RUN or LAP
Ovf  output  1  sticky overflow flag

Behaviour:
- Reset (Rst=1 at clock edge):
  - State IDLE; Count=0, Disp=0, Running=0, Ovf=0.
  - Edge-detect history regs for Tick_in, Start and Lap are set to 1, so inputs already high at reset release produce no edge.
- Edge detect: tick = Tick_in & ~tick_q; similarly start_e and lap_e. The history regs update every cycle.
- Latency: Count changes on the same Clk_in edge that first samples Tick_in high. Disp (when not frozen) and Running update on that same edge. Zero extra pipeline.
- States and transitions (Clear overrides all):
  - IDLE: start_e -> RUN. lap_e ignored.
  - RUN: start_e -> PAUSE; lap_e -> LAP.
  - LAP: start_e -> PAUSE, and Disp resumes tracking Count; lap_e -> RUN.
  - PAUSE: start_e -> RUN; lap_e ignored.
  - DONE (WRAP=0 only): entered on saturation; only Clear or Rst leaves.
- Clear=1: next state IDLE; Count=0, Disp=0, Ovf=0. Clear has priority over a tick, start_e or lap_e in the same cycle.
- Counting:
  - Only in RUN or LAP, on tick.
  - Digit 0 increments. Digit k increments iff digits 0..k-1 are all 9 and a tick occurs. A digit at 9 that increments becomes 0.
  - Full ripple carry resolves in one cycle.
  - Each digit stays within 0-9. Values A-F never appear.
- All-9s plus tick:
  - WRAP=1: Count -> 0, Ovf <- 1 (sticky until Clear/Rst), state unchanged.
  - WRAP=0: Count holds all-9s, Ovf <- 1, state -> DONE, Running=0.
- Simultaneous events:
  - tick with start_e in RUN/LAP: the tick is counted, then PAUSE.
  - tick with start_e in IDLE/PAUSE: the tick is not counted.
  - start_e with lap_e in the same cycle: start_e wins, lap_e discarded.
- Disp:
  - Equals the next Count value in all states except LAP.
  - In LAP, holds the Count value present at the LAP-entry edge, including any tick counted on that edge.
- Mid-operation reset or Clear: takes effect on the next edge regardless of state or pending ticks.

Test Plan:
1. Reset, then Start pulse, then Tick_in from a /10 divider (5 high, 5 low), 25 rising edges -> Count=0x0025, Disp=0x0025, Running=1, Ovf=0.
2. In RUN at Count=0x0009, one tick -> 0x0010; preload to 0x0999 via ticks, one tick -> 0x1000; each digit stays 0-9 throughout.
3. WRAP=1: reach 0x9999, one tick -> Count=0x0000, Ovf=1, Running=1. WRAP=0 instance: -> Count=0x9999, Ovf=1, Running=0, DONE; further ticks and Start ignored; Clear -> 0x0000, Ovf=0, IDLE.
4. Count=0x0012, Lap pulse, 5 ticks -> Disp=0x0012, Count=0x0017; Lap again -> Disp=0x0017; Start pulse -> Running=0, ticks ignored.
5. In the same cycle, tick and Start rise in RUN at 0x0003 -> Count=0x0004, PAUSE. In the same cycle, tick and Clear -> Count=0x0000, IDLE.
6. Tick_in held high and Start held high across reset release -> no count and no state change until each input falls and rises again.
